// File: rtl/display_scan_controller.sv
// display_scan_controller: row-scanned PWM driver for a small LED matrix.
// Frame data is double-buffered. A load during a scan is held in a pending
// buffer and moves to the active buffer only at the end of a frame.
module display_scan_controller #(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 4,
    parameter int unsigned PRESCALE = 8
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,
    input  logic                             load_enable,
    input  logic [ROWS-1:0][COLS-1:0][3:0]   pixels,
    input  logic [3:0]                       brightness_value,
    input  logic                             enable,
    output logic [ROWS-1:0]                  row_sel,
    output logic [COLS-1:0]                  col_drive,
    output logic                             busy,
    output logic                             frame_done,
    output logic                             output_enable,
    output logic [3:0]                       pixel
);

    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned PWM_W = 4;
    localparam int unsigned INT_W = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] BLANK = 2'd2;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PWM_W-1:0] PWM_LAST = '1;

    typedef logic [ROWS-1:0][COLS-1:0][INT_W-1:0] frame_t;

    logic [1:0]       state, state_nxt;
    logic [ROW_W-1:0] row, row_nxt;
    logic [PWM_W-1:0] pwm_cnt, pwm_nxt;
    logic [PRE_W-1:0] pre_cnt, pre_nxt;
    frame_t           act_pix, act_pix_nxt;
    frame_t           pend_pix, pend_pix_nxt;
    logic [3:0]       act_bri, act_bri_nxt;
    logic [3:0]       pend_bri, pend_bri_nxt;
    logic             pend_flag, pend_flag_nxt;
    logic [ROWS-1:0]  row_sel_nxt;
    logic [COLS-1:0]  col_nxt;
    logic             frame_end_c;
    logic [3:0]       pixel_nxt;

    // PWM threshold: intensity scaled by (brightness+1), upper nibble of the 8-bit result
    function automatic logic [INT_W-1:0] thr_f(input logic [INT_W-1:0] p, input logic [3:0] b);
        logic [8:0] prod;
        prod = 9'(p) * (9'(b) + 9'd1);
        return 4'(prod >> 4);
    endfunction

    // Next-state, buffer and output decode; outputs are computed from next values so they align with state
    always_comb begin
        state_nxt     = state;
        row_nxt       = row;
        pwm_nxt       = pwm_cnt;
        pre_nxt       = pre_cnt;
        act_pix_nxt   = act_pix;
        act_bri_nxt   = act_bri;
        pend_pix_nxt  = pend_pix;
        pend_bri_nxt  = pend_bri;
        pend_flag_nxt = pend_flag;
        row_sel_nxt   = '0;
        col_nxt       = '0;
        pixel_nxt     = pixel;
        frame_end_c   = (state == BLANK) && (row == ROW_LAST);

        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = SCAN;
                    row_nxt   = '0;
                    pwm_nxt   = '0;
                    pre_nxt   = '0;
                end
            end
            SCAN: begin
                if (pre_cnt == PRE_LAST) begin
                    pre_nxt = '0;
                    if (pwm_cnt == PWM_LAST) begin
                        pwm_nxt   = '0;
                        state_nxt = BLANK;
                    end else begin
                        pwm_nxt = pwm_cnt + PWM_W'(1);
                    end
                end else begin
                    pre_nxt = pre_cnt + PRE_W'(1);
                end
            end
            BLANK: begin
                pwm_nxt = '0;
                pre_nxt = '0;
                if (row == ROW_LAST) begin
                    row_nxt   = '0;
                    state_nxt = enable ? SCAN : IDLE;
                end else begin
                    row_nxt   = row + ROW_W'(1);
                    state_nxt = SCAN;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Buffer handling: direct load when idle, pending load while scanning, swap at frame end
        if (frame_end_c) begin
            pixel_nxt     = pixel + 4'd1;
            pend_flag_nxt = 1'b0;
            if (load_enable) begin
                act_pix_nxt = pixels;
                act_bri_nxt = brightness_value;
            end else if (pend_flag) begin
                act_pix_nxt = pend_pix;
                act_bri_nxt = pend_bri;
            end
        end else if (load_enable) begin
            if (state == IDLE) begin
                act_pix_nxt = pixels;
                act_bri_nxt = brightness_value;
            end else begin
                pend_pix_nxt  = pixels;
                pend_bri_nxt  = brightness_value;
                pend_flag_nxt = 1'b1;
            end
        end

        if (state_nxt == SCAN) begin
            row_sel_nxt = ROWS'(1) << row_nxt;
            for (int c = 0; c < COLS; c++) begin
                col_nxt[c] = pwm_nxt < thr_f(act_pix_nxt[row_nxt][c], act_bri_nxt);
            end
        end
    end

    // State, counters, buffers and registered outputs
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state         <= IDLE;
            row           <= '0;
            pwm_cnt       <= '0;
            pre_cnt       <= '0;
            act_pix       <= '0;
            act_bri       <= 4'b0010;
            pend_pix      <= '0;
            pend_bri      <= '0;
            pend_flag     <= 1'b0;
            row_sel       <= '0;
            col_drive     <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            output_enable <= 1'b0;
            pixel         <= '0;
        end else begin
            state         <= state_nxt;
            row           <= row_nxt;
            pwm_cnt       <= pwm_nxt;
            pre_cnt       <= pre_nxt;
            act_pix       <= act_pix_nxt;
            act_bri       <= act_bri_nxt;
            pend_pix      <= pend_pix_nxt;
            pend_bri      <= pend_bri_nxt;
            pend_flag     <= pend_flag_nxt;
            row_sel       <= row_sel_nxt;
            col_drive     <= col_nxt;
            busy          <= (state_nxt != IDLE);
            frame_done    <= (state_nxt == BLANK) && (row_nxt == ROW_LAST);
            output_enable <= (state_nxt == BLANK) && (row_nxt == ROW_LAST);
            pixel         <= pixel_nxt;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller at default parameters (frame = 516 cycles).
module tb_display_scan_controller;

    localparam int unsigned FRAME = 516;
    localparam int unsigned ROWP  = 129;

    logic                   tb_HCLK;
    logic                   tb_HRESETn;
    logic                   load_enable;
    logic [3:0][3:0][3:0]   pixels;
    logic [3:0]             brightness_value;
    logic                   enable;
    logic [3:0]             row_sel;
    logic [3:0]             col_drive;
    logic                   busy;
    logic                   frame_done;
    logic                   output_enable;
    logic [3:0]             pixel;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int s0;
    int on_cnt;
    int row_cnt;

    display_scan_controller dut (
        .HCLK             (tb_HCLK),
        .HRESETn          (tb_HRESETn),
        .load_enable      (load_enable),
        .pixels           (pixels),
        .brightness_value (brightness_value),
        .enable           (enable),
        .row_sel          (row_sel),
        .col_drive        (col_drive),
        .busy             (busy),
        .frame_done       (frame_done),
        .output_enable    (output_enable),
        .pixel            (pixel)
    );

    initial tb_HCLK = 1'b0;
    always #5 tb_HCLK = ~tb_HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge tb_HCLK);
        cyc++;
    endtask

    task automatic go(input int t);
        while (cyc < t) step();
    endtask

    // Sample a full 128-cycle row dwell starting at the current cycle
    task automatic count_row(input logic [3:0] exp_row);
        on_cnt  = 0;
        row_cnt = 0;
        for (int i = 0; i < 128; i++) begin
            if (col_drive == 4'hF) on_cnt++;
            if (row_sel == exp_row) row_cnt++;
            step();
        end
    endtask

    initial begin
        tb_HRESETn       = 1'b0;
        load_enable      = 1'b0;
        pixels           = '0;
        brightness_value = '0;
        enable           = 1'b0;
        step();
        step();
        chk("rst_row_sel", row_sel, 4'h0);
        chk("rst_col", col_drive, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_oe", output_enable, 1'b0);
        chk("rst_pixel", pixel, 4'h0);
        tb_HRESETn = 1'b1;
        step();
        chk("idle_busy", busy, 1'b0);

        // Full-scale frame, loaded while idle
        pixels           = {16{4'hF}};
        brightness_value = 4'd15;
        load_enable      = 1'b1;
        enable           = 1'b1;
        step();
        load_enable = 1'b0;
        s0 = cyc;
        chk("scan0_col_first", col_drive, 4'hF);
        chk("scan0_busy", busy, 1'b1);
        count_row(4'b0001);
        chk("row0_dwell", row_cnt, 128);
        chk("row0_on_cycles", on_cnt, 120);
        chk("blank_row_sel", row_sel, 4'h0);
        chk("blank_col", col_drive, 4'h0);
        chk("blank_busy", busy, 1'b1);
        step();
        chk("row1_sel", row_sel, 4'b0010);
        chk("row1_col", col_drive, 4'hF);
        go(s0 + FRAME - 2);
        chk("pre_end_fd", frame_done, 1'b0);
        step();
        chk("f1_fd", frame_done, 1'b1);
        chk("f1_oe", output_enable, 1'b1);
        chk("f1_blank_row", row_sel, 4'h0);
        chk("f1_pixel_hold", pixel, 4'h0);
        step();
        chk("f1_fd_clear", frame_done, 1'b0);
        chk("f1_oe_clear", output_enable, 1'b0);
        chk("f1_pixel", pixel, 4'h1);
        chk("f2_row0", row_sel, 4'b0001);

        // Mid-row-1 load goes to pending; current frame keeps full thresholds
        go(s0 + FRAME + ROWP + 11);
        pixels           = {16{4'h8}};
        brightness_value = 4'd2;
        load_enable      = 1'b1;
        step();
        load_enable = 1'b0;
        go(s0 + FRAME + 2*ROWP);
        chk("f2_row2_sel", row_sel, 4'b0100);
        chk("f2_row2_old_col", col_drive, 4'hF);
        go(s0 + FRAME + 2*ROWP + 119);
        chk("f2_row2_on_119", col_drive, 4'hF);
        step();
        chk("f2_row2_off_120", col_drive, 4'h0);
        go(s0 + 2*FRAME - 1);
        chk("f2_fd", frame_done, 1'b1);
        step();
        chk("f2_pixel", pixel, 4'h2);
        count_row(4'b0001);
        chk("f3_row0_dwell", row_cnt, 128);
        chk("f3_thr1_on", on_cnt, 8);

        // Pending load overridden by a live load on the frame-end cycle (brightness 0 -> thr 0)
        go(s0 + 2*FRAME + ROWP + 11);
        pixels           = {16{4'hF}};
        brightness_value = 4'd15;
        load_enable      = 1'b1;
        step();
        load_enable = 1'b0;
        go(s0 + 3*FRAME - 1);
        chk("f3_fd", frame_done, 1'b1);
        pixels           = {16{4'h8}};
        brightness_value = 4'd0;
        load_enable      = 1'b1;
        step();
        load_enable = 1'b0;
        chk("f4_pixel", pixel, 4'h3);
        count_row(4'b0001);
        chk("f4_row0_dwell", row_cnt, 128);
        chk("f4_thr0_on", on_cnt, 0);

        // Run on to the pixel counter wrap; toggle enable inside frame 16 without stopping
        go(s0 + 15*FRAME);
        chk("f16_pixel", pixel, 4'hF);
        step();
        enable = 1'b0;
        go(s0 + 15*FRAME + 400);
        enable = 1'b1;
        go(s0 + 16*FRAME);
        chk("wrap_pixel", pixel, 4'h0);
        chk("reenable_row0", row_sel, 4'b0001);
        chk("reenable_busy", busy, 1'b1);

        // Disable mid-row 2: frame completes then idles
        go(s0 + 16*FRAME + 300);
        enable = 1'b0;
        go(s0 + 17*FRAME - 1);
        chk("f17_fd", frame_done, 1'b1);
        chk("f17_busy", busy, 1'b1);
        step();
        chk("idle_after_busy", busy, 1'b0);
        chk("idle_after_row", row_sel, 4'h0);
        chk("idle_after_pixel", pixel, 4'h1);
        step();
        step();
        step();
        chk("idle_stays", busy, 1'b0);
        chk("idle_no_fd", frame_done, 1'b0);

        // Async reset mid-row
        enable = 1'b1;
        step();
        chk("rescan_row0", row_sel, 4'b0001);
        go(cyc + 40);
        tb_HRESETn = 1'b0;
        #1;
        chk("async_row_sel", row_sel, 4'h0);
        chk("async_busy", busy, 1'b0);
        chk("async_pixel", pixel, 4'h0);
        step();
        tb_HRESETn = 1'b1;
        enable     = 1'b0;
        step();
        chk("post_rst_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
